// File: rtl/irq_priority_sequencer.sv
// Sequential interrupt controller: latches 3 x NCH requests, arbitrates A>B>C, presents one
// vector over valid/ready and holds it in service until EOI. Optional macro: IRQ_ROUND_ROBIN_EN.
module irq_priority_sequencer #(
  parameter int NCH  = 9,
  parameter int EDGE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NCH-1:0]     req_a,
  input  logic [NCH-1:0]     req_b,
  input  logic [NCH-1:0]     req_c,
  input  logic [NCH-1:0]     en,
  output logic               irq_valid,
  input  logic               irq_ready,
  output logic [1:0]         irq_bus,
  output logic [3:0]         irq_chan,
  input  logic               eoi,
  output logic               busy,
  output logic [3*NCH-1:0]   pend
);

  // Handshake: a vector transfers on the cycle irq_valid & irq_ready are both high; irq_bus and
  // irq_chan stay stable while irq_valid is high, and irq_valid only drops early when the
  // presented bit stops being eligible (its enable was removed).

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_PRESENT = 2'd2,
    S_SERVICE = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_valid;
  logic            r_busy;
  logic [1:0]      r_bus;
  logic [3:0]      r_chan;
  logic [NCH-1:0]  r_pend  [3];
  logic [NCH-1:0]  r_req_q [3];
  logic [NCH-1:0]  r_en_q;
`ifdef IRQ_ROUND_ROBIN_EN
  logic [3:0]      r_ptr   [3];
`endif

  logic [NCH-1:0]  w_req   [3];
  logic [NCH-1:0]  w_set   [3];
  logic [NCH-1:0]  w_clr   [3];
  logic [NCH-1:0]  w_elig  [3];
  logic            w_hit   [3];
  logic [3:0]      w_chan  [3];
  logic            w_any;
  logic [1:0]      w_sel_bus;
  logic [3:0]      w_sel_chan;
  logic            w_accept;
  logic            w_pres_elig;
  int              w_idx;

  assign w_req[0] = req_a;
  assign w_req[1] = req_b;
  assign w_req[2] = req_c;

  // Enable is sampled alongside the request edge so both paths see the same 3-cycle latency.
  always_comb begin
    w_accept    = (r_state == S_PRESENT) && irq_ready;
    w_pres_elig = 1'b0;
    for (int b = 0; b < 3; b++) begin
      w_set[b]  = (EDGE != 0) ? (w_req[b] & ~r_req_q[b]) : w_req[b];
      w_elig[b] = r_pend[b] & r_en_q;
      w_clr[b]  = '0;
      for (int i = 0; i < NCH; i++) begin
        w_clr[b][i] = w_accept && (r_bus == 2'(b)) && (r_chan == 4'(i));
        if ((r_bus == 2'(b)) && (r_chan == 4'(i)) && w_elig[b][i])
          w_pres_elig = 1'b1;
      end
    end
  end

  // Descending scan: the last hit written is the first in search order.
  always_comb begin
    w_idx = 0;
    for (int b = 0; b < 3; b++) begin
      w_hit[b]  = 1'b0;
      w_chan[b] = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
`ifdef IRQ_ROUND_ROBIN_EN
        w_idx = (int'(r_ptr[b]) + 1 + i) % NCH;
`else
        w_idx = i;
`endif
        if (w_elig[b][w_idx]) begin
          w_hit[b]  = 1'b1;
          w_chan[b] = 4'(w_idx);
        end
      end
    end
  end

  always_comb begin
    w_any      = w_hit[0] | w_hit[1] | w_hit[2];
    w_sel_bus  = 2'd3;
    w_sel_chan = 4'd0;
    if (w_hit[0]) begin
      w_sel_bus  = 2'd0;
      w_sel_chan = w_chan[0];
    end else if (w_hit[1]) begin
      w_sel_bus  = 2'd1;
      w_sel_chan = w_chan[1];
    end else if (w_hit[2]) begin
      w_sel_bus  = 2'd2;
      w_sel_chan = w_chan[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_bus   <= 2'd3;
      r_chan  <= 4'd0;
      r_en_q  <= '0;
      for (int b = 0; b < 3; b++) begin
        r_pend[b]  <= '0;
        r_req_q[b] <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
        r_ptr[b]   <= 4'(NCH - 1);
`endif
      end
    end else begin
      r_en_q <= en;
      // Set after clear so a request arriving on the acceptance cycle is kept.
      for (int b = 0; b < 3; b++) begin
        r_req_q[b] <= w_req[b];
        r_pend[b]  <= (r_pend[b] & ~w_clr[b]) | w_set[b];
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) r_state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          if (w_any) begin
            r_bus   <= w_sel_bus;
            r_chan  <= w_sel_chan;
            r_valid <= 1'b1;
            r_state <= S_PRESENT;
          end else begin
            r_bus   <= 2'd3;
            r_state <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (irq_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
            for (int b = 0; b < 3; b++)
              if (r_bus == 2'(b)) r_ptr[b] <= r_chan;
`endif
          end else if (!w_pres_elig) begin
            r_valid <= 1'b0;
            r_bus   <= 2'd3;
            r_state <= S_IDLE;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign irq_valid = r_valid;
  assign irq_bus   = r_bus;
  assign irq_chan  = r_chan;
  assign busy      = r_busy;
  assign pend      = {r_pend[2], r_pend[1], r_pend[0]};

endmodule

// File: tb/tb_irq_priority_sequencer.sv
// Directed bench for irq_priority_sequencer (NCH=9, EDGE=1); inputs driven and outputs
// sampled on the falling edge.
module tb_irq_priority_sequencer;

  localparam int NCH = 9;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   req_a, req_b, req_c, en;
  logic             irq_valid, irq_ready, eoi, busy;
  logic [1:0]       irq_bus;
  logic [3:0]       irq_chan;
  logic [3*NCH-1:0] pend;

  int total;
  int bad;

  irq_priority_sequencer #(.NCH(NCH), .EDGE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .en        (en),
    .irq_valid (irq_valid),
    .irq_ready (irq_ready),
    .irq_bus   (irq_bus),
    .irq_chan  (irq_chan),
    .eoi       (eoi),
    .busy      (busy),
    .pend      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (irq_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (irq_valid === 1'b1) ok = 1'b1;
  endtask

  task automatic wait_low(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (irq_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (irq_valid === 1'b0) ok = 1'b1;
  endtask

  task automatic pulse_ready();
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", irq_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (irq_bus !== 2'd3) begin bad++; $display("FAIL reset_bus got=%0d want=3", irq_bus); end
    total++; if (irq_chan !== 4'd0) begin bad++; $display("FAIL reset_chan got=%0d want=0", irq_chan); end
    total++; if (pend !== 27'd0) begin bad++; $display("FAIL reset_pend got=%h want=0", pend); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_a = 9'h008;
    tick();
    req_a = '0;
    total++; if (pend !== 27'h8) begin bad++; $display("FAIL single_pend_set got=%h want=8", pend); end
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_lat1 got=%0b want=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_lat2 got=%0b want=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL single_lat3 got=%0b want=1", irq_valid); end
    total++; if (irq_bus !== 2'd0 || irq_chan !== 4'd3) begin bad++; $display("FAIL single_vec got=%0d/%0d want=0/3", irq_bus, irq_chan); end
    pulse_eoi();
    total++; if (irq_valid !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_eoi_in_present got=v%0b b%0b want=v1 b0", irq_valid, busy); end
    pulse_ready();
    total++; if (irq_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_accept got=v%0b b%0b want=v0 b1", irq_valid, busy); end
    total++; if (pend !== 27'd0) begin bad++; $display("FAIL single_pend_clr got=%h want=0", pend); end
    total++; if (irq_bus !== 2'd0 || irq_chan !== 4'd3) begin bad++; $display("FAIL single_hold got=%0d/%0d want=0/3", irq_bus, irq_chan); end
    repeat (3) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_hold got=%0b want=1", busy); end
    pulse_eoi();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_eoi got=%0b want=0", busy); end
  endtask

  task automatic test_spurious();
    irq_ready = 1'b1;
    eoi = 1'b1;
    tick();
    tick();
    irq_ready = 1'b0;
    eoi = 1'b0;
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL spur_valid got=%0b want=0", irq_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spur_busy got=%0b want=0", busy); end
    total++; if (pend !== 27'd0) begin bad++; $display("FAIL spur_pend got=%h want=0", pend); end
  endtask

  task automatic test_back_to_back();
    int eb[3];
    int ec[3];
    eb = '{0, 1, 2};
    ec = '{8, 5, 0};
    req_a = 9'h100;
    req_b = 9'h020;
    req_c = 9'h001;
    tick();
    req_a = '0;
    req_b = '0;
    req_c = '0;
    total++; if (pend !== 27'h0044100) begin bad++; $display("FAIL b2b_pend got=%h want=0044100", pend); end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap%0d got=%0b want=0", k, irq_valid); end
      tick();
      total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid%0d got=%0b want=1", k, irq_valid); end
      total++; if (irq_bus !== 2'(eb[k]) || irq_chan !== 4'(ec[k])) begin
        bad++; $display("FAIL b2b_vec%0d got=%0d/%0d want=%0d/%0d", k, irq_bus, irq_chan, eb[k], ec[k]);
      end
      pulse_ready();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy%0d got=%0b want=1", k, busy); end
      pulse_eoi();
    end
    total++; if (pend !== 27'd0) begin bad++; $display("FAIL b2b_drain got=%h want=0", pend); end
  endtask

  task automatic test_no_preempt();
    bit ok;
    req_c = 9'h008;
    tick();
    req_c = '0;
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL nopre_timeout1 got=0 want=1"); end
    req_a = 9'h001;
    tick();
    req_a = '0;
    tick();
    tick();
    total++; if (irq_valid !== 1'b1 || irq_bus !== 2'd2 || irq_chan !== 4'd3) begin
      bad++; $display("FAIL nopre_hold got=v%0b %0d/%0d want=v1 2/3", irq_valid, irq_bus, irq_chan);
    end
    pulse_ready();
    pulse_eoi();
    wait_valid(10, ok);
    total++; if (!ok || irq_bus !== 2'd0 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL nopre_next got=v%0b %0d/%0d want=v1 0/0", irq_valid, irq_bus, irq_chan);
    end
    pulse_ready();
    pulse_eoi();
  endtask

  task automatic test_enable_gate();
    en = 9'h1FB;
    req_a = 9'h004;
    tick();
    req_a = '0;
    repeat (5) tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL gate_masked got=%0b want=0", irq_valid); end
    total++; if (pend[2] !== 1'b1) begin bad++; $display("FAIL gate_pend got=%0b want=1", pend[2]); end
    en = '1;
    tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL gate_lat1 got=%0b want=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL gate_lat2 got=%0b want=0", irq_valid); end
    tick();
    total++; if (irq_valid !== 1'b1 || irq_bus !== 2'd0 || irq_chan !== 4'd2) begin
      bad++; $display("FAIL gate_vec got=v%0b %0d/%0d want=v1 0/2", irq_valid, irq_bus, irq_chan);
    end
    pulse_ready();
    pulse_eoi();
  endtask

  task automatic test_withdraw();
    bit ok;
    req_b = 9'h010;
    tick();
    req_b = '0;
    wait_valid(10, ok);
    total++; if (!ok || irq_bus !== 2'd1 || irq_chan !== 4'd4) begin
      bad++; $display("FAIL wd_first got=v%0b %0d/%0d want=v1 1/4", irq_valid, irq_bus, irq_chan);
    end
    en = 9'h1EF;
    wait_low(5, ok);
    total++; if (!ok) begin bad++; $display("FAIL wd_drop got=%0b want=0", irq_valid); end
    total++; if (irq_bus !== 2'd3) begin bad++; $display("FAIL wd_bus got=%0d want=3", irq_bus); end
    total++; if (pend[13] !== 1'b1) begin bad++; $display("FAIL wd_pend got=%0b want=1", pend[13]); end
    en = '1;
    wait_valid(10, ok);
    total++; if (!ok || irq_bus !== 2'd1 || irq_chan !== 4'd4) begin
      bad++; $display("FAIL wd_again got=v%0b %0d/%0d want=v1 1/4", irq_valid, irq_bus, irq_chan);
    end
    pulse_ready();
    total++; if (pend[13] !== 1'b0) begin bad++; $display("FAIL wd_clr got=%0b want=0", pend[13]); end
    pulse_eoi();
  endtask

  task automatic test_set_wins();
    bit ok;
    req_b = 9'h002;
    tick();
    req_b = '0;
    wait_valid(10, ok);
    total++; if (!ok || irq_bus !== 2'd1 || irq_chan !== 4'd1) begin
      bad++; $display("FAIL sw_first got=v%0b %0d/%0d want=v1 1/1", irq_valid, irq_bus, irq_chan);
    end
    irq_ready = 1'b1;
    req_b = 9'h002;
    tick();
    irq_ready = 1'b0;
    req_b = '0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL sw_busy got=%0b want=1", busy); end
    total++; if (pend[10] !== 1'b1) begin bad++; $display("FAIL sw_pend_kept got=%0b want=1", pend[10]); end
    pulse_eoi();
    wait_valid(10, ok);
    total++; if (!ok || irq_bus !== 2'd1 || irq_chan !== 4'd1) begin
      bad++; $display("FAIL sw_regrant got=v%0b %0d/%0d want=v1 1/1", irq_valid, irq_bus, irq_chan);
    end
    pulse_ready();
    total++; if (pend[10] !== 1'b0) begin bad++; $display("FAIL sw_clr got=%0b want=0", pend[10]); end
    pulse_eoi();
  endtask

  task automatic test_mid_reset();
    bit ok;
    req_a = 9'h020;
    req_c = 9'h080;
    tick();
    req_a = '0;
    req_c = '0;
    wait_valid(10, ok);
    total++; if (!ok) begin bad++; $display("FAIL mrst_timeout got=0 want=1"); end
    rst_n = 1'b0;
    tick();
    total++; if (irq_valid !== 1'b0 || busy !== 1'b0 || irq_bus !== 2'd3 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL mrst_outs got=v%0b b%0b %0d/%0d want=v0 b0 3/0", irq_valid, busy, irq_bus, irq_chan);
    end
    total++; if (pend !== 27'd0) begin bad++; $display("FAIL mrst_pend got=%h want=0", pend); end
    rst_n = 1'b1;
    repeat (5) tick();
    total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL mrst_quiet got=%0b want=0", irq_valid); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_ch[4];
`ifdef IRQ_ROUND_ROBIN_EN
    exp_ch = '{0, 1, 0, 1};
`else
    exp_ch = '{0, 0, 0, 0};
`endif
    req_a = 9'h003;
    tick();
    req_a = '0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(10, ok);
      total++; if (!ok || irq_bus !== 2'd0 || irq_chan !== 4'(exp_ch[k])) begin
        bad++; $display("FAIL rr_grant%0d got=v%0b %0d/%0d want=v1 0/%0d", k, irq_valid, irq_bus, irq_chan, exp_ch[k]);
      end
      pulse_ready();
      req_a = 9'h003;
      tick();
      req_a = '0;
      pulse_eoi();
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    en        = '1;
    irq_ready = 1'b0;
    eoi       = 1'b0;
    tick();
    test_reset();
    test_single();
    test_spurious();
    test_back_to_back();
    test_no_preempt();
    test_enable_gate();
    test_withdraw();
    test_set_wins();
    test_mid_reset();
    test_round_robin();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
